// File: rtl/mdu_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: operation codes,
// FSM states, default latencies and a small arithmetic helper.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_MADD  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int CNT_W           = 8;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding architectural HI/LO.
// Optional madd (code 7) is enabled by defining MDU_MADD_EN.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] SourceA,
    input  logic [31:0] SourceB,
    input  logic [2:0]  MDUctrl,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    mdu_state_e        state_q, state_d;
    mdu_op_e           op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;
    logic              busy_q, busy_d;

    mdu_op_e           op_s;
    logic              madd_ok_s;
    logic              is_mult_s, is_div_s;
    logic [63:0]       prod_s_s, prod_u_s, madd_sum_s;
    logic [31:0]       divu_b_s, quot_u_s, rem_u_s;
    logic [31:0]       abs_a_s, abs_b_s, quot_mag_s, rem_mag_s, quot_s_s, rem_s_s;

    assign op_s = mdu_op_e'(MDUctrl);

`ifdef MDU_MADD_EN
    assign madd_ok_s  = 1'b1;
    assign madd_sum_s = {hi_q, lo_q} + prod_s_s;
`else
    assign madd_ok_s  = 1'b0;
    assign madd_sum_s = 64'd0;
`endif

    assign is_mult_s = (op_s == MDU_MULT) || (op_s == MDU_MULTU) || ((op_s == MDU_MADD) && madd_ok_s);
    assign is_div_s  = (op_s == MDU_DIV) || (op_s == MDU_DIVU);

    // Result datapath from latched operands; divisors are forced nonzero so
    // a divide by zero never evaluates, its result is simply not written.
    always_comb begin
        prod_s_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u_s   = {32'd0, a_q} * {32'd0, b_q};
        divu_b_s   = (b_q == 32'd0) ? 32'd1 : b_q;
        quot_u_s   = a_q / divu_b_s;
        rem_u_s    = a_q % divu_b_s;
        abs_a_s    = abs32(a_q);
        abs_b_s    = (b_q == 32'd0) ? 32'd1 : abs32(b_q);
        quot_mag_s = abs_a_s / abs_b_s;
        rem_mag_s  = abs_a_s % abs_b_s;
        quot_s_s   = (a_q[31] ^ b_q[31]) ? (~quot_mag_s + 32'd1) : quot_mag_s;
        rem_s_s    = a_q[31] ? (~rem_mag_s + 32'd1) : rem_mag_s;
    end

    // Next-state logic: op launch, countdown, completion write and mthi/mtlo.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (Start && is_mult_s) begin
                    state_d = ST_MULT;
                    op_d    = op_s;
                    a_d     = SourceA;
                    b_d     = SourceB;
                    cnt_d   = CNT_W'(MULT_CYCLES - 1);
                    busy_d  = 1'b1;
                end else if (Start && is_div_s) begin
                    state_d = ST_DIV;
                    op_d    = op_s;
                    a_d     = SourceA;
                    b_d     = SourceB;
                    cnt_d   = CNT_W'(DIV_CYCLES - 1);
                    busy_d  = 1'b1;
                end else if (!Start && !busy_q && (op_s == MDU_MTHI)) begin
                    hi_d = SourceA;
                end else if (!Start && !busy_q && (op_s == MDU_MTLO)) begin
                    lo_d = SourceA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MULT, ST_DIV: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    case (op_q)
                        MDU_MULT:  {hi_d, lo_d} = prod_s_s;
                        MDU_MULTU: {hi_d, lo_d} = prod_u_s;
                        MDU_MADD:  {hi_d, lo_d} = madd_ok_s ? madd_sum_s : {hi_q, lo_q};
                        MDU_DIV: begin
                            if (b_q != 32'd0) begin
                                hi_d = rem_s_s;
                                lo_d = quot_s_s;
                            end else begin
                                hi_d = hi_q;
                            end
                        end
                        MDU_DIVU: begin
                            if (b_q != 32'd0) begin
                                hi_d = rem_u_s;
                                lo_d = quot_u_s;
                            end else begin
                                hi_d = hi_q;
                            end
                        end
                        default: hi_d = hi_q;
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and architectural register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= MDU_NONE;
            cnt_q   <= {CNT_W{1'b0}};
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: a longint reference model predicts HI/LO and busy
// length at issue time; a monitor checks them when Busy falls.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] SourceA = 32'd0;
    logic [31:0] SourceB = 32'd0;
    logic [2:0]  MDUctrl = 3'd0;
    logic        Start = 1'b0;
    logic        Busy;
    logic [31:0] HI, LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu dut (
        .clk(clk), .reset(reset), .SourceA(SourceA), .SourceB(SourceB),
        .MDUctrl(MDUctrl), .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: applies one started operation to m_hi/m_lo.
    function automatic int model_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        logic [63:0]     acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (c)
            3'd1: begin p = sa * sb; {m_hi, m_lo} = p; return 5; end
            3'd2: begin p = ua * ub; {m_hi, m_lo} = p; return 5; end
            3'd3: begin
                if (b != 32'd0) begin
                    q = sa / sb; r = sa % sb;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end
                return 10;
            end
            3'd4: begin
                if (b != 32'd0) begin
                    p = ua / ub; m_lo = p[31:0];
                    p = ua % ub; m_hi = p[31:0];
                end
                return 10;
            end
`ifdef MDU_MADD_EN
            3'd7: begin
                acc = {m_hi, m_lo};
                p = sa * sb;
                acc = acc + p;
                {m_hi, m_lo} = acc;
                return 5;
            end
`endif
            default: return 0;
        endcase
    endfunction

    task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        int len;
        @(negedge clk);
        MDUctrl = c; SourceA = a; SourceB = b; Start = 1'b1;
        len = model_op(c, a, b);
        if (len > 0) exp_q.push_back('{hi: m_hi, lo: m_lo, len: len});
        @(negedge clk);
        Start = 1'b0; MDUctrl = 3'd0;
        check("busy_after_start", {63'd0, Busy}, {63'd0, (len > 0)});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!Busy && exp_q.size() == 0) return;
            @(negedge clk);
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_idle: timeout with Busy=%0b pending=%0d", Busy, exp_q.size());
        exp_q.delete();
    endtask

    task automatic mt(input logic [2:0] c, input logic [31:0] v);
        @(negedge clk);
        MDUctrl = c; SourceA = v; Start = 1'b0;
        if (c == 3'd5) m_hi = v; else m_lo = v;
        @(negedge clk);
        MDUctrl = 3'd0;
        check("mt_hi", {32'd0, HI}, {32'd0, m_hi});
        check("mt_lo", {32'd0, LO}, {32'd0, m_lo});
    endtask

    // Monitor: sample after each edge, pop and compare when Busy falls.
    initial begin
        logic prev_busy;
        int   busy_len;
        exp_t e;
        prev_busy = 1'b0;
        busy_len = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                exp_q.delete();
                busy_len = 0;
            end else if (Busy) begin
                busy_len++;
            end else if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL completion: unexpected Busy fall at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("result_hi", {32'd0, HI}, {32'd0, e.hi});
                    check("result_lo", {32'd0, LO}, {32'd0, e.lo});
                    check("busy_len", 64'(busy_len), 64'(e.len));
                end
                busy_len = 0;
            end
            prev_busy = Busy;
        end
    end

    initial begin
        logic [2:0]  c;
        logic [31:0] a, b;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", {63'd0, Busy}, 64'd0);
        check("reset_hi", {32'd0, HI}, 64'd0);
        check("reset_lo", {32'd0, LO}, 64'd0);

        issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002); wait_idle();
        check("mult_hi", {32'd0, HI}, 64'hFFFF_FFFF);
        issue(3'd2, 32'hFFFF_FFFF, 32'h0000_0002); wait_idle();
        check("multu_hi", {32'd0, HI}, 64'h1);
        issue(3'd3, 32'hFFFF_FFF9, 32'h0000_0002); wait_idle();
        check("div_lo", {32'd0, LO}, 64'hFFFF_FFFD);
        issue(3'd4, 32'd7, 32'd2); wait_idle();
        check("divu_hi", {32'd0, HI}, 64'h1);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
        check("div_ovf_lo", {32'd0, LO}, 64'h8000_0000);

        mt(3'd5, 32'h1234_5678);
        issue(3'd4, 32'd99, 32'd0);
        @(negedge clk); MDUctrl = 3'd6; SourceA = 32'hDEAD_BEEF;
        @(negedge clk); MDUctrl = 3'd0;
        wait_idle();
        check("divz_lo", {32'd0, LO}, {32'd0, m_lo});

        // Abort a mult with reset partway through, then run one normally.
        issue(3'd1, 32'd3, 32'd4);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        check("abort_busy", {63'd0, Busy}, 64'd0);
        check("abort_hi", {32'd0, HI}, 64'd0);
        check("abort_lo", {32'd0, LO}, 64'd0);
        issue(3'd1, 32'd3, 32'd4); wait_idle();

        // Start during Busy and operand changes must not disturb the op.
        issue(3'd2, 32'd1000, 32'd3000);
        @(negedge clk); Start = 1'b1; MDUctrl = 3'd3; SourceA = 32'd5; SourceB = 32'd7;
        @(negedge clk); Start = 1'b0; MDUctrl = 3'd0; SourceA = 32'd11; SourceB = 32'd13;
        wait_idle();
        check("busy_start_lo", {32'd0, LO}, 64'd3000000);

        mt(3'd5, 32'd0);
        mt(3'd6, 32'hFFFF_FFFF);
        issue(3'd7, 32'd1, 32'd1); wait_idle();
`ifdef MDU_MADD_EN
        check("madd", {HI, LO}, 64'h1_0000_0000);
`else
        check("madd_off", {HI, LO}, 64'h0000_0000_FFFF_FFFF);
`endif

        for (int i = 0; i < 40; i++) begin
            c = 3'($urandom_range(1, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: b = b;
            endcase
            if (c == 3'd5 || c == 3'd6) begin
                mt(c, a);
            end else begin
                issue(c, a, b);
                wait_idle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
